spi_slave_target: RTL and testbench

//  SPI target (slave) end of the link driven by spi_module in master mode: receives MOSI bytes, returns MISO bytes.

---
 rtl/spi_slave_target_pkg.sv | 18 +
 rtl/spi_slave_target_if.sv | 41 ++++
 rtl/spi_slave_target_sync_edge.sv | 31 +++
 rtl/spi_slave_target.sv | 221 ++++++++++++++++++++++
 tb/tb_spi_slave_target.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_target_pkg.sv
// Shared types and defaults for the oversampled SPI target.
package spi_slave_target_pkg;

  localparam int SPI_DATA_W_DFLT = 8;
  localparam int SPI_SYNC_DFLT   = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_tgt_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsbfe;
  } spi_mode_t;

endpackage

// File: rtl/spi_slave_target_if.sv
// Pin and host-side bundle of the SPI target; slave = the target, master = whoever drives it.
interface spi_slave_target_if
  import spi_slave_target_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W_DFLT
);

  logic              i_SCK;
  logic              i_SS;
  logic              i_MOSI;
  logic              o_MISO;
  logic              o_MISO_oe;
  logic              i_cpol;
  logic              i_cpha;
  logic              i_lsbfe;
  logic [DATA_W-1:0] i_tx_data;
  logic              i_tx_wr;
  logic              o_tx_empty;
  logic              o_tx_underrun;
  logic [DATA_W-1:0] o_rx_data;
  logic              o_rx_full;
  logic              i_rx_rd;
  logic              o_overrun;
  logic              i_flag_clr;
  logic              o_busy;

  modport slave (
    input  i_SCK, i_SS, i_MOSI, i_cpol, i_cpha, i_lsbfe,
    input  i_tx_data, i_tx_wr, i_rx_rd, i_flag_clr,
    output o_MISO, o_MISO_oe, o_tx_empty, o_tx_underrun,
    output o_rx_data, o_rx_full, o_overrun, o_busy
  );

  modport master (
    output i_SCK, i_SS, i_MOSI, i_cpol, i_cpha, i_lsbfe,
    output i_tx_data, i_tx_wr, i_rx_rd, i_flag_clr,
    input  o_MISO, o_MISO_oe, o_tx_empty, o_tx_underrun,
    input  o_rx_data, o_rx_full, o_overrun, o_busy
  );

endinterface

// File: rtl/spi_slave_target_sync_edge.sv
// Multi-flop synchronizer with single-cycle rise/fall pulses on the synchronized level.
module spi_sync_edge
  import spi_slave_target_pkg::*;
#(
  parameter int SYNC_STAGES = SPI_SYNC_DFLT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Resetting to 0 means an SS held low through reset never looks like a new fall.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_target.sv
// SPI target running on the system clock: oversampled pins, shifter, 1-deep RX/TX buffers, sticky flags.
module spi_slave_target
  import spi_slave_target_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W_DFLT,
  parameter int SYNC_STAGES = SPI_SYNC_DFLT
) (
  input logic               i_sys_clk,
  input logic               i_sys_rst,
  spi_slave_target_if.slave bus
);

  localparam int                 CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(DATA_W - 1);

  logic sck_rise, sck_fall, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk_i (i_sys_clk),
    .rst_i (i_sys_rst),
    .d_i   (bus.i_SCK),
    .rise_o(sck_rise),
    .fall_o(sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
    .clk_i (i_sys_clk),
    .rst_i (i_sys_rst),
    .d_i   (bus.i_SS),
    .rise_o(ss_rise),
    .fall_o(ss_fall)
  );

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) mosi_sync_q <= '0;
    else           mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.i_MOSI};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  spi_tgt_state_e    state_q, state_d;
  spi_mode_t         mode_q, mode_d, mode_in;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] hold_q, hold_d, rx_new_q, rx_new_d, rx_data_q, rx_data_d;
  logic              miso_q, miso_d, tx_empty_q, tx_empty_d, pend_unr_q, pend_unr_d;
  logic              done_q, done_d, rx_full_q, rx_full_d;
  logic              unr_q, unr_d, ovr_q, ovr_d;

  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic frame_start, frame_abort, sample_en, shift_en, active;
  logic byte_done, reload, unr_set, ovr_set;
  logic [DATA_W-1:0] load_val, rx_shifted, tx_shifted;

  function automatic logic out_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  assign lead_edge   = mode_q.cpol ? sck_fall : sck_rise;
  assign trail_edge  = mode_q.cpol ? sck_rise : sck_fall;
  assign sample_edge = mode_q.cpha ? trail_edge : lead_edge;
  assign shift_edge  = mode_q.cpha ? lead_edge : trail_edge;

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACTIVE:  if (ss_rise) state_d = IDLE;
      default: if (ss_fall) state_d = ACTIVE;
    endcase
  end

  always_comb begin
    frame_start = 1'b0;
    frame_abort = 1'b0;
    sample_en   = 1'b0;
    shift_en    = 1'b0;
    active      = 1'b0;
    case (state_q)
      ACTIVE: begin
        active      = 1'b1;
        frame_abort = ss_rise;
        sample_en   = sample_edge & ~ss_rise;
        shift_en    = shift_edge & ~ss_rise;
      end
      default: frame_start = ss_fall;
    endcase
  end

  assign mode_in    = {bus.i_cpol, bus.i_cpha, bus.i_lsbfe};
  assign load_val   = tx_empty_q ? {DATA_W{1'b1}} : hold_q;
  assign rx_shifted = mode_q.lsbfe ? {mosi_s, rx_sr_q[DATA_W-1:1]} : {rx_sr_q[DATA_W-2:0], mosi_s};
  assign tx_shifted = mode_q.lsbfe ? {1'b0, tx_sr_q[DATA_W-1:1]} : {tx_sr_q[DATA_W-2:0], 1'b0};
  assign byte_done  = sample_en && (bit_cnt_q == LAST_BIT);
  assign reload     = frame_start || byte_done;

  always_comb begin
    mode_d     = mode_q;
    bit_cnt_d  = bit_cnt_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    miso_d     = miso_q;
    hold_d     = hold_q;
    tx_empty_d = tx_empty_q;
    pend_unr_d = pend_unr_q;
    done_d     = 1'b0;
    rx_new_d   = rx_new_q;
    rx_data_d  = rx_data_q;
    rx_full_d  = rx_full_q;
    unr_set    = 1'b0;
    ovr_set    = 1'b0;

    if (frame_start) begin
      mode_d     = mode_in;
      bit_cnt_d  = '0;
      tx_sr_d    = load_val;
      pend_unr_d = 1'b0;
      tx_empty_d = 1'b1;
      unr_set    = tx_empty_q;
      if (!mode_in.cpha) miso_d = out_bit(load_val, mode_in.lsbfe);
    end

    if (frame_abort) pend_unr_d = 1'b0;

    // A reload from an empty buffer only counts as underrun once the next byte really starts.
    if (sample_en) begin
      rx_sr_d = rx_shifted;
      if (pend_unr_q && bit_cnt_q == '0) begin
        unr_set    = 1'b1;
        pend_unr_d = 1'b0;
      end
      if (byte_done) begin
        bit_cnt_d  = '0;
        done_d     = 1'b1;
        rx_new_d   = rx_shifted;
        tx_sr_d    = load_val;
        pend_unr_d = tx_empty_q;
        tx_empty_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end

    if (shift_en) begin
      if (bit_cnt_q != '0) begin
        tx_sr_d = tx_shifted;
        miso_d  = out_bit(tx_shifted, mode_q.lsbfe);
      end else begin
        miso_d = out_bit(tx_sr_q, mode_q.lsbfe);
      end
    end

    if (bus.i_tx_wr && (tx_empty_q || reload)) begin
      hold_d     = bus.i_tx_data;
      tx_empty_d = 1'b0;
    end

    if (done_q) begin
      if (rx_full_q && !bus.i_rx_rd) begin
        ovr_set = 1'b1;
      end else begin
        rx_data_d = rx_new_q;
        rx_full_d = 1'b1;
      end
    end else if (bus.i_rx_rd) begin
      rx_full_d = 1'b0;
    end

    unr_d = unr_set | (unr_q & ~bus.i_flag_clr);
    ovr_d = ovr_set | (ovr_q & ~bus.i_flag_clr);
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      mode_q     <= '0;
      bit_cnt_q  <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      miso_q     <= 1'b0;
      hold_q     <= '0;
      tx_empty_q <= 1'b1;
      pend_unr_q <= 1'b0;
      done_q     <= 1'b0;
      rx_new_q   <= '0;
      rx_data_q  <= '0;
      rx_full_q  <= 1'b0;
      unr_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      miso_q     <= miso_d;
      hold_q     <= hold_d;
      tx_empty_q <= tx_empty_d;
      pend_unr_q <= pend_unr_d;
      done_q     <= done_d;
      rx_new_q   <= rx_new_d;
      rx_data_q  <= rx_data_d;
      rx_full_q  <= rx_full_d;
      unr_q      <= unr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.o_MISO        = miso_q;
  assign bus.o_MISO_oe     = active;
  assign bus.o_busy        = active;
  assign bus.o_tx_empty    = tx_empty_q;
  assign bus.o_tx_underrun = unr_q;
  assign bus.o_rx_data     = rx_data_q;
  assign bus.o_rx_full     = rx_full_q;
  assign bus.o_overrun     = ovr_q;

endmodule

// File: tb/tb_spi_slave_target.sv
// Bench for spi_slave_target: bit-banged SPI master, vector table plus hand-written corner sequences.
module tb_spi_slave_target;
  import spi_slave_target_pkg::*;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int NV = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_slave_target_if #(.DATA_W(W)) bus ();

  spi_slave_target #(.DATA_W(W), .SYNC_STAGES(2)) dut (
    .i_sys_clk(clk),
    .i_sys_rst(rst),
    .bus      (bus)
  );

  typedef struct {
    logic         cpol;
    logic         cpha;
    logic         lsbfe;
    logic [W-1:0] tx;
    logic [W-1:0] mosi;
    logic [W-1:0] exp_rx;
    logic [W-1:0] exp_miso;
    logic [W-1:0] exp_seq;
  } vec_t;

  vec_t         tab[NV];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] sb_q[$];
  logic         cur_cpol, cur_cpha, cur_lsbfe;
  logic [W-1:0] miso_a, seq_a, miso_b, seq_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mode(input logic cpol, input logic cpha, input logic lsbfe);
    cur_cpol = cpol; cur_cpha = cpha; cur_lsbfe = lsbfe;
    bus.i_cpol = cpol; bus.i_cpha = cpha; bus.i_lsbfe = lsbfe;
    bus.i_SCK = cpol;
    cyc(6);
  endtask

  task automatic pulse_wr(input logic [W-1:0] d);
    bus.i_tx_data = d; bus.i_tx_wr = 1'b1; cyc(1); bus.i_tx_wr = 1'b0;
  endtask

  task automatic pulse_rd();
    bus.i_rx_rd = 1'b1; cyc(1); bus.i_rx_rd = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.i_flag_clr = 1'b1; cyc(1); bus.i_flag_clr = 1'b0;
  endtask

  task automatic ss_low();
    bus.i_SS = 1'b0; cyc(H);
  endtask

  task automatic ss_high();
    cyc(H); bus.i_SS = 1'b1; cyc(H);
  endtask

  // seq collects MISO bits in wire order, first bit ends up in the MSB after 8 bits
  task automatic xfer(input logic [W-1:0] mosi, input int nbits,
                      output logic [W-1:0] miso, output logic [W-1:0] seq);
    int idx;
    miso = '0; seq = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = cur_lsbfe ? i : W - 1 - i;
      if (!cur_cpha) begin
        bus.i_MOSI = mosi[idx];
        cyc(H);
        bus.i_SCK = ~cur_cpol;
        miso[idx] = bus.o_MISO;
        seq = {seq[W-2:0], bus.o_MISO};
        cyc(H);
        bus.i_SCK = cur_cpol;
      end else begin
        bus.i_SCK = ~cur_cpol;
        bus.i_MOSI = mosi[idx];
        cyc(H);
        bus.i_SCK = cur_cpol;
        miso[idx] = bus.o_MISO;
        seq = {seq[W-2:0], bus.o_MISO};
        cyc(H);
      end
    end
  endtask

  task automatic wait_rx(input string name);
    int t = 0;
    logic [W-1:0] exp;
    while (bus.o_rx_full !== 1'b1 && t < 100) begin
      cyc(1);
      t++;
    end
    chk({name, " rx_full"}, bus.o_rx_full, 1);
    if (bus.o_rx_full === 1'b1) begin
      chk({name, " sb depth"}, sb_q.size(), 1);
      if (sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        chk({name, " rx_data"}, bus.o_rx_data, exp);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tab[0] = '{1'b0, 1'b0, 1'b0, 8'h3C, 8'hA5, 8'hA5, 8'h3C, 8'h3C};
    tab[1] = '{1'b1, 1'b1, 1'b1, 8'h81, 8'h0F, 8'h0F, 8'h81, 8'h81};
    tab[2] = '{1'b0, 1'b1, 1'b0, 8'h96, 8'h5C, 8'h5C, 8'h96, 8'h96};
    tab[3] = '{1'b1, 1'b0, 1'b1, 8'hE7, 8'h24, 8'h24, 8'hE7, 8'hE7};
    tab[4] = '{1'b0, 1'b0, 1'b1, 8'h01, 8'h80, 8'h80, 8'h01, 8'h80};

    bus.i_SCK = 1'b0; bus.i_SS = 1'b1; bus.i_MOSI = 1'b0;
    bus.i_cpol = 1'b0; bus.i_cpha = 1'b0; bus.i_lsbfe = 1'b0;
    bus.i_tx_data = '0; bus.i_tx_wr = 1'b0; bus.i_rx_rd = 1'b0; bus.i_flag_clr = 1'b0;
    cur_cpol = 1'b0; cur_cpha = 1'b0; cur_lsbfe = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(5);

    chk("reset miso", bus.o_MISO, 0);
    chk("reset miso_oe", bus.o_MISO_oe, 0);
    chk("reset tx_empty", bus.o_tx_empty, 1);
    chk("reset rx_data", bus.o_rx_data, 0);
    chk("reset rx_full", bus.o_rx_full, 0);
    chk("reset overrun", bus.o_overrun, 0);
    chk("reset underrun", bus.o_tx_underrun, 0);
    chk("reset busy", bus.o_busy, 0);

    for (int v = 0; v < NV; v++) begin
      set_mode(tab[v].cpol, tab[v].cpha, tab[v].lsbfe);
      pulse_wr(tab[v].tx);
      chk($sformatf("v%0d tx_empty", v), bus.o_tx_empty, 0);
      sb_q.push_back(tab[v].exp_rx);
      ss_low();
      chk($sformatf("v%0d busy", v), bus.o_busy, 1);
      chk($sformatf("v%0d miso_oe", v), bus.o_MISO_oe, 1);
      xfer(tab[v].mosi, W, miso_a, seq_a);
      ss_high();
      chk($sformatf("v%0d master rx", v), miso_a, tab[v].exp_miso);
      chk($sformatf("v%0d miso order", v), seq_a, tab[v].exp_seq);
      wait_rx($sformatf("v%0d", v));
      cyc(3);
      chk($sformatf("v%0d rx_full level", v), bus.o_rx_full, 1);
      pulse_rd();
      chk($sformatf("v%0d rx_full clr", v), bus.o_rx_full, 0);
      chk($sformatf("v%0d overrun", v), bus.o_overrun, 0);
      chk($sformatf("v%0d underrun", v), bus.o_tx_underrun, 0);
      chk($sformatf("v%0d oe idle", v), bus.o_MISO_oe, 0);
    end

    // back-to-back bytes in one SS window, no read in between
    set_mode(1'b0, 1'b0, 1'b0);
    pulse_wr(8'h11);
    sb_q.push_back(8'h12);
    ss_low();
    xfer(8'h12, W, miso_a, seq_a);
    xfer(8'h34, W, miso_b, seq_b);
    ss_high();
    chk("b2b first miso", miso_a, 8'h11);
    chk("b2b second miso", miso_b, 8'hFF);
    wait_rx("b2b");
    cyc(10);
    chk("b2b overrun", bus.o_overrun, 1);
    chk("b2b underrun", bus.o_tx_underrun, 1);
    chk("b2b rx_data kept", bus.o_rx_data, 8'h12);
    pulse_clr();
    chk("b2b overrun clr", bus.o_overrun, 0);
    chk("b2b underrun clr", bus.o_tx_underrun, 0);
    pulse_rd();
    chk("b2b rx_full clr", bus.o_rx_full, 0);

    // frame with nothing written
    chk("unr tx_empty", bus.o_tx_empty, 1);
    sb_q.push_back(8'h6B);
    ss_low();
    chk("unr flag at start", bus.o_tx_underrun, 1);
    xfer(8'h6B, W, miso_a, seq_a);
    ss_high();
    chk("unr master rx", miso_a, 8'hFF);
    wait_rx("unr");
    pulse_rd();
    pulse_clr();
    chk("unr flag clr", bus.o_tx_underrun, 0);

    // SS released after 4 bits
    pulse_wr(8'h24);
    ss_low();
    xfer(8'hC3, 4, miso_a, seq_a);
    ss_high();
    cyc(10);
    chk("abort rx_full", bus.o_rx_full, 0);
    chk("abort miso_oe", bus.o_MISO_oe, 0);
    chk("abort busy", bus.o_busy, 0);
    pulse_wr(8'h66);
    sb_q.push_back(8'h5A);
    ss_low();
    xfer(8'h5A, W, miso_a, seq_a);
    ss_high();
    chk("abort next miso", miso_a, 8'h66);
    wait_rx("abort next");
    pulse_rd();

    // second write while holding buffer is full is dropped
    pulse_wr(8'h77);
    pulse_wr(8'h88);
    chk("wr ignore tx_empty", bus.o_tx_empty, 0);
    sb_q.push_back(8'h3E);
    ss_low();
    xfer(8'h3E, W, miso_a, seq_a);
    ss_high();
    chk("wr ignore miso", miso_a, 8'h77);
    wait_rx("wr ignore");
    pulse_rd();

    // reset in the middle of a byte while SS stays low
    pulse_wr(8'hAB);
    ss_low();
    xfer(8'hF0, 3, miso_a, seq_a);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(8);
    chk("mid rst miso_oe", bus.o_MISO_oe, 0);
    chk("mid rst busy", bus.o_busy, 0);
    chk("mid rst tx_empty", bus.o_tx_empty, 1);
    chk("mid rst rx_data", bus.o_rx_data, 0);
    chk("mid rst rx_full", bus.o_rx_full, 0);
    chk("mid rst miso", bus.o_MISO, 0);
    bus.i_SS = 1'b1;
    cyc(H);
    pulse_wr(8'h42);
    sb_q.push_back(8'h99);
    ss_low();
    xfer(8'h99, W, miso_a, seq_a);
    ss_high();
    chk("post rst miso", miso_a, 8'h42);
    wait_rx("post rst");
    pulse_rd();
    chk("sb drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
